// File: rtl/viterbi_acs_unit.sv
// Add-compare-select stage for an 8-state Viterbi decoder.
// Holds the path metrics, produces per-state survivor decisions and the best state.

module viterbi_acs_lane #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_p0,
  input  logic [PM_W-1:0] pm_p1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);
  logic [PM_W:0]   sum0, sum1;
  logic [PM_W-1:0] c0, c1;

  always_comb begin
    sum0   = {1'b0, pm_p0} + {{(PM_W-1){1'b0}}, bm0};
    sum1   = {1'b0, pm_p1} + {{(PM_W-1){1'b0}}, bm1};
    // Any carry out pins the candidate at the all-ones ceiling.
    c0     = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    c1     = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
    dec    = (c1 < c0);
    pm_new = dec ? c1 : c0;
  end
endmodule

module viterbi_acs_unit #(
  parameter int PM_W     = 8,
  parameter int INIT_PEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       bm0_flat,
  input  logic [15:0]       bm1_flat,
  output logic              out_valid,
  output logic [7:0]        decisions,
  output logic [2:0]        best_state,
  output logic [8*PM_W-1:0] pm_flat
);
  localparam int NUM_ST = 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic   do_step;

  logic [NUM_ST-1:0][PM_W-1:0] pm_q, init_pm, base_pm, new_pm, norm_pm;
  logic [NUM_ST-1:0]           dec_w, msb_w;
  logic [2:0]                  best_w;
  logic [PM_W-1:0]             best_pm;

  always_comb begin
    for (int s = 0; s < NUM_ST; s++)
      init_pm[s] = (s == 0) ? '0 : PM_W'(INIT_PEN);
  end

  // A start pulse makes the step (if any) run from the initial metrics.
  assign base_pm = start ? init_pm : pm_q;

  for (genvar s = 0; s < NUM_ST; s++) begin : g_lane
    viterbi_acs_lane #(.PM_W(PM_W)) u_lane (
      .pm_p0  (base_pm[s/2]),
      .pm_p1  (base_pm[4 + s/2]),
      .bm0    (bm0_flat[2*s+1:2*s]),
      .bm1    (bm1_flat[2*s+1:2*s]),
      .pm_new (new_pm[s]),
      .dec    (dec_w[s])
    );
    assign msb_w[s] = new_pm[s][PM_W-1];
  end

  // Once every metric has crossed half range, dropping the MSB rebases them all.
  always_comb begin
    for (int s = 0; s < NUM_ST; s++) begin
      norm_pm[s] = new_pm[s];
      if (&msb_w) norm_pm[s][PM_W-1] = 1'b0;
    end
  end

  always_comb begin
    best_w  = '0;
    best_pm = norm_pm[0];
    for (int s = 1; s < NUM_ST; s++) begin
      if (norm_pm[s] < best_pm) begin
        best_w  = 3'(s);
        best_pm = norm_pm[s];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          do_step = in_valid;
        end
      end
      RUN:     do_step = in_valid;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pm_q       <= init_pm;
      out_valid  <= 1'b0;
      decisions  <= '0;
      best_state <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= do_step;
      if (do_step) begin
        pm_q       <= norm_pm;
        decisions  <= dec_w;
        best_state <= best_w;
      end else if (start) begin
        pm_q <= init_pm;
      end
    end
  end

  assign pm_flat = pm_q;
endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Directed self-checking bench for viterbi_acs_unit (PM_W=8, INIT_PEN=16).

module tb_viterbi_acs_unit;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] bm0_flat, bm1_flat;
  logic        out_valid;
  logic [7:0]  decisions;
  logic [2:0]  best_state;
  logic [63:0] pm_flat;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] PM_INIT = 64'h1010101010101000;
  localparam logic [63:0] PM_B2   = 64'h1010101010100000;

  viterbi_acs_unit #(.PM_W(8), .INIT_PEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .bm0_flat   (bm0_flat),
    .bm1_flat   (bm1_flat),
    .out_valid  (out_valid),
    .decisions  (decisions),
    .best_state (best_state),
    .pm_flat    (pm_flat)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic iv, input logic [15:0] b0, input logic [15:0] b1);
    start = st; in_valid = iv; bm0_flat = b0; bm1_flat = b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    n_cmp++; if (pm_flat !== PM_INIT) begin n_err++; $display("FAIL reset_pm got=%h exp=%h", pm_flat, PM_INIT); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (decisions !== 8'h00) begin n_err++; $display("FAIL reset_dec got=%h exp=00", decisions); end
    n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL reset_best got=%0d exp=0", best_state); end
    rst = 1'b1;
    // IDLE ignores in_valid without start
    drive(1'b0, 1'b1, 16'h0, 16'hFFFF);
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_ignore_valid got=%b exp=0", out_valid); end
    n_cmp++; if (pm_flat !== PM_INIT) begin n_err++; $display("FAIL idle_ignore_pm got=%h exp=%h", pm_flat, PM_INIT); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 16'h0000, 16'hAAAA);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_cmp++; if (decisions !== 8'h00) begin n_err++; $display("FAIL basic_dec got=%h exp=00", decisions); end
    n_cmp++; if (pm_flat !== PM_B2) begin n_err++; $display("FAIL basic_pm got=%h exp=%h", pm_flat, PM_B2); end
    n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL basic_best got=%0d exp=0", best_state); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single_pulse got=%b exp=0", out_valid); end
  endtask

  task automatic test_ties();
    logic [63:0] exp_pm [3];
    exp_pm[0] = 64'h1010101000000000;
    exp_pm[1] = 64'h0;
    exp_pm[2] = 64'h0;
    drive(1'b0, 1'b1, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ties_valid step=%0d got=%b exp=1", k, out_valid); end
      n_cmp++; if (decisions !== 8'h00) begin n_err++; $display("FAIL ties_dec step=%0d got=%h exp=00", k, decisions); end
      n_cmp++; if (pm_flat !== exp_pm[k]) begin n_err++; $display("FAIL ties_pm step=%0d got=%h exp=%h", k, pm_flat, exp_pm[k]); end
      n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL ties_best step=%0d got=%0d exp=0", k, best_state); end
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_decisions();
    // p1 branches cheaper where p0 sits at INIT_PEN
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (decisions !== 8'hFC) begin n_err++; $display("FAIL dec_bits got=%h exp=fc", decisions); end
    n_cmp++; if (pm_flat !== 64'h1010101010100303) begin n_err++; $display("FAIL dec_pm got=%h exp=1010101010100303", pm_flat); end
    n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL dec_best got=%0d exp=0", best_state); end
  endtask

  task automatic test_best_state();
    drive(1'b1, 1'b1, 16'h0000, 16'hAAAA);
    tick();
    drive(1'b0, 1'b1, 16'hFF0F, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (pm_flat !== 64'h1313131300000303) begin n_err++; $display("FAIL best_pm got=%h exp=1313131300000303", pm_flat); end
    n_cmp++; if (best_state !== 3'd2) begin n_err++; $display("FAIL best_lowest_idx got=%0d exp=2", best_state); end
    n_cmp++; if (decisions !== 8'h00) begin n_err++; $display("FAIL best_dec got=%h exp=00", decisions); end
  endtask

  task automatic test_back_to_back_norm();
    int gaps = 0;
    drive(1'b1, 1'b1, 16'hAAAA, 16'hAAAA);
    tick();
    if (out_valid !== 1'b1) gaps++;
    drive(1'b0, 1'b1, 16'hAAAA, 16'hAAAA);
    for (int k = 2; k <= 63; k++) begin
      tick();
      if (out_valid !== 1'b1) gaps++;
    end
    n_cmp++; if (pm_flat !== 64'h7E7E7E7E7E7E7E7E) begin n_err++; $display("FAIL norm_pre_pm got=%h exp=7e7e7e7e7e7e7e7e", pm_flat); end
    tick();
    if (out_valid !== 1'b1) gaps++;
    n_cmp++; if (pm_flat !== 64'h0) begin n_err++; $display("FAIL norm_wrap_pm got=%h exp=0", pm_flat); end
    n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL norm_best got=%0d exp=0", best_state); end
    tick();
    if (out_valid !== 1'b1) gaps++;
    n_cmp++; if (pm_flat !== 64'h0202020202020202) begin n_err++; $display("FAIL norm_post_pm got=%h exp=0202020202020202", pm_flat); end
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL norm_valid_gaps got=%0d exp=0", gaps); end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_stall_restart();
    int bad_pm = 0, bad_vld = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pm_flat !== 64'h0202020202020202) bad_pm++;
      if (out_valid !== 1'b0) bad_vld++;
    end
    n_cmp++; if (bad_pm !== 0) begin n_err++; $display("FAIL stall_pm_hold got=%0d bad exp=0", bad_pm); end
    n_cmp++; if (bad_vld !== 0) begin n_err++; $display("FAIL stall_valid got=%0d bad exp=0", bad_vld); end
    drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (pm_flat !== PM_INIT) begin n_err++; $display("FAIL restart_pm got=%h exp=%h", pm_flat, PM_INIT); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL restart_valid got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL restart_valid2 got=%b exp=0", out_valid); end
    // Restart leaves the FSM in RUN, so a plain in_valid steps from init
    drive(1'b0, 1'b1, 16'h0000, 16'hAAAA);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL restart_run_valid got=%b exp=1", out_valid); end
    n_cmp++; if (pm_flat !== PM_B2) begin n_err++; $display("FAIL restart_run_pm got=%h exp=%h", pm_flat, PM_B2); end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (pm_flat !== PM_INIT) begin n_err++; $display("FAIL rstmid_pm got=%h exp=%h", pm_flat, PM_INIT); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    n_cmp++; if (decisions !== 8'h00) begin n_err++; $display("FAIL rstmid_dec got=%h exp=00", decisions); end
    n_cmp++; if (best_state !== 3'd0) begin n_err++; $display("FAIL rstmid_best got=%0d exp=0", best_state); end
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick(); tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_valid got=%b exp=0", out_valid); end
    n_cmp++; if (pm_flat !== PM_INIT) begin n_err++; $display("FAIL rstmid_idle_pm got=%h exp=%h", pm_flat, PM_INIT); end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    test_reset();
    test_basic();
    test_ties();
    test_decisions();
    test_best_state();
    test_back_to_back_norm();
    test_stall_restart();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
